// File: rtl/dcache_axi_ctrl_pkg.sv
// rtl/dcache_axi_ctrl_pkg.sv - shared states, request kinds and AXI constants for the D-cache AXI master
package dcache_axi_ctrl_pkg;

  localparam logic [1:0] AXI_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_AR   = 6'b000010,
    ST_R    = 6'b000100,
    ST_AW_W = 6'b001000,
    ST_B    = 6'b010000,
    ST_DONE = 6'b100000
  } state_t;

  typedef enum logic [1:0] {
    KIND_CA  = 2'd0,
    KIND_UCR = 2'd1,
    KIND_UCW = 2'd2
  } kind_t;

endpackage

// File: rtl/dcache_line_buf.sv
// rtl/dcache_line_buf.sv - beat counter plus word-indexed refill line register
module dcache_line_buf #(
  parameter int WORDS = 8,
  parameter int CNT_W = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  capture,
  input  logic [31:0]           word,
  output logic [32*WORDS-1:0]   line
);

  logic [CNT_W-1:0] cnt_q;

  // clear only restarts the counter; the line keeps its last contents until overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      line  <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (capture) begin
      line[32*cnt_q +: 32] <= word;
      cnt_q                <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dcache_axi_ctrl.sv
// rtl/dcache_axi_ctrl.sv - AXI master for D-cache line refills and uncached single-beat accesses
module dcache_axi_ctrl
  import dcache_axi_ctrl_pkg::*;
#(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] AXI_ID     = 4'd1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ca_rreq_i,
  input  logic                    uc_rreq_i,
  input  logic                    uc_wreq_i,
  input  logic [31:0]             addr_i,
  input  logic [3:0]              wen_i,
  input  logic [31:0]             wdata_i,
  output logic                    rend_o,
  output logic                    wend_o,
  output logic [32*LINE_WORDS-1:0] line_o,
  output logic [31:0]             uc_rdata_o,
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [3:0]              wid,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  state_t      state_q, state_d;
  kind_t       kind_q;
  logic [31:0] addr_q, wdata_q, uc_rdata_q;
  logic [3:0]  wen_q;
  logic        aw_done_q, w_done_q;
  logic        r_hs, aw_hs, w_hs;
  logic        unused_resp;

  assign r_hs        = rvalid & rready;
  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign unused_resp = ^{rresp, bresp};

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = (kind_q == KIND_CA) ? 8'(LINE_WORDS - 1) : 8'd0;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_INCR;
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_INCR;
  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign wlast   = 1'b1;
  assign uc_rdata_o = uc_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // in AW_W each valid is the inverse of its done flag, so "done or ready" means that channel finishes
  always_comb begin
    state_d = state_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    rend_o  = 1'b0;
    wend_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (uc_rreq_i)      state_d = ST_AR;
        else if (uc_wreq_i) state_d = ST_AW_W;
        else if (ca_rreq_i) state_d = ST_AR;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_d = ST_DONE;
      end
      ST_AW_W: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if ((aw_done_q || awready) && (w_done_q || wready)) state_d = ST_B;
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) state_d = ST_DONE;
      end
      ST_DONE: begin
        rend_o  = (kind_q != KIND_UCW);
        wend_o  = (kind_q == KIND_UCW);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q     <= KIND_UCR;
      addr_q     <= '0;
      wen_q      <= '0;
      wdata_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      uc_rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        if (uc_rreq_i) begin
          kind_q <= KIND_UCR;
          addr_q <= addr_i;
        end else if (uc_wreq_i) begin
          kind_q  <= KIND_UCW;
          addr_q  <= addr_i;
          wen_q   <= wen_i;
          wdata_q <= wdata_i;
        end else if (ca_rreq_i) begin
          kind_q <= KIND_CA;
          addr_q <= {addr_i[31:5], 5'b0};
        end
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (r_hs && kind_q == KIND_UCR) uc_rdata_q <= rdata;
    end
  end

  dcache_line_buf #(.WORDS(LINE_WORDS)) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == ST_IDLE),
    .capture (r_hs && kind_q == KIND_CA),
    .word    (rdata),
    .line    (line_o)
  );

endmodule

// File: tb/tb_dcache_axi_ctrl.sv
// tb/tb_dcache_axi_ctrl.sv - self-checking bench for dcache_axi_ctrl
`timescale 1ns/1ps
module tb_dcache_axi_ctrl;

  localparam int K_CA = 0, K_UCR = 1, K_UCW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic ca_rreq_i, uc_rreq_i, uc_wreq_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0] wen_i;
  logic rend_o, wend_o;
  logic [255:0] line_o;
  logic [31:0] uc_rdata_o;
  logic [3:0] arid, awid, wid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0] wstrb;

  always #5 clk = ~clk;

  dcache_axi_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ca_rreq_i(ca_rreq_i), .uc_rreq_i(uc_rreq_i), .uc_wreq_i(uc_wreq_i),
    .addr_i(addr_i), .wen_i(wen_i), .wdata_i(wdata_i),
    .rend_o(rend_o), .wend_o(wend_o), .line_o(line_o), .uc_rdata_o(uc_rdata_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_cmp = 0, n_fail = 0;
  int rend_cnt = 0, wend_cnt = 0;
  logic [255:0] exp_line = '0;
  logic [31:0]  exp_uc = '0;

  always @(posedge clk) begin
    if (rend_o) rend_cnt++;
    if (wend_o) wend_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference rules: refills are line-aligned 8-beat bursts, uncached accesses are single beats at the raw address
  function automatic logic [31:0] m_addr(input int kind, input logic [31:0] a);
    return (kind == K_CA) ? (a & 32'hFFFF_FFE0) : a;
  endfunction

  function automatic logic [7:0] m_len(input int kind);
    return (kind == K_CA) ? 8'd7 : 8'd0;
  endfunction

  task automatic drop_req(input int kind);
    case (kind)
      K_CA:    ca_rreq_i = 1'b0;
      K_UCR:   uc_rreq_i = 1'b0;
      default: uc_wreq_i = 1'b0;
    endcase
  endtask

  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [3:0] wen,
                         input logic [31:0] wd, input logic [31:0] base,
                         input int d_a, input int d_w, input int stall,
                         input logic [31:0] e_addr, input logic [7:0] e_len, input int abort_at);
    int r0, w0, t, nb, mx;
    r0 = rend_cnt;
    w0 = wend_cnt;
    addr_i = addr; wen_i = wen; wdata_i = wd;
    case (kind)
      K_CA:    ca_rreq_i = 1'b1;
      K_UCR:   uc_rreq_i = 1'b1;
      default: uc_wreq_i = 1'b1;
    endcase
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(arvalid || awvalid) && t < 20);
    chk("start_latency", t, 1);
    if (!(arvalid || awvalid)) begin
      drop_req(kind);
      return;
    end

    if (kind != K_UCW) begin
      chk("arvalid", arvalid, 1);
      chk("awvalid_in_read", awvalid, 0);
      chk("araddr", araddr, e_addr);
      chk("arlen", arlen, e_len);
      chk("arsize_burst_id", {arsize, arburst, arid}, {3'b010, 2'b01, 4'd1});
      chk("rready_in_ar", rready, 0);
      for (int i = 0; i < d_a; i++) begin
        @(negedge clk);
        chk("ar_stable", {arvalid, araddr, arlen}, {1'b1, e_addr, e_len});
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("ar_dropped", arvalid, 0);
      chk("rready_in_r", rready, 1);
      nb = (kind == K_CA) ? 8 : 1;
      for (int i = 0; i < nb; i++) begin
        int s;
        if (i == abort_at) begin
          #2 rst_n = 1'b0;
          #1;
          chk("reset_async_ctrl", {arvalid, rready, awvalid, wvalid, bready, rend_o, wend_o}, 0);
          chk("reset_async_line", line_o, 0);
          chk("reset_async_uc", uc_rdata_o, 0);
          drop_req(kind);
          exp_line = '0;
          exp_uc = '0;
          @(negedge clk);
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          chk("reset_no_rend", rend_cnt - r0, 0);
          chk("reset_idle", {arvalid, rready}, 0);
          return;
        end
        s = $urandom_range(0, stall);
        for (int j = 0; j < s; j++) begin
          @(negedge clk);
          chk("rready_stall", rready, 1);
        end
        rvalid = 1'b1;
        rdata  = base + 32'(i);
        rlast  = (i == nb - 1);
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        if (kind == K_CA) exp_line[32*(i%8) +: 32] = base + 32'(i);
        else              exp_uc = base + 32'(i);
        if (i < nb - 1) chk("no_early_rend", rend_o, 0);
      end
      chk("rend_pulse", {rend_o, wend_o}, 2'b10);
      chk("line", line_o, exp_line);
      chk("uc_rdata", uc_rdata_o, exp_uc);
      drop_req(kind);
      @(negedge clk);
      chk("rend_cleared", {rend_o, rready}, 0);
      chk("pulse_counts", {16'(rend_cnt - r0), 16'(wend_cnt - w0)}, {16'd1, 16'd0});
    end else begin
      chk("aw_w_together", {awvalid, wvalid, arvalid, rready}, 4'b1100);
      chk("awaddr", awaddr, e_addr);
      chk("aw_len_size_burst_id", {awlen, awsize, awburst, awid}, {e_len, 3'b010, 2'b01, 4'd1});
      chk("w_fields", {wid, wdata, wstrb, wlast}, {4'd1, wd, wen, 1'b1});
      mx = (d_a > d_w) ? d_a : d_w;
      for (int c = 0; c <= mx; c++) begin
        if (c > 0) @(negedge clk);
        chk("awvalid_cycle", awvalid, (c <= d_a));
        chk("wvalid_cycle", wvalid, (c <= d_w));
        awready = (c == d_a);
        wready  = (c == d_w);
      end
      @(negedge clk);
      awready = 1'b0;
      wready  = 1'b0;
      chk("aw_w_done", {awvalid, wvalid, bready}, 3'b001);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("bready_wait", {bready, wend_o}, 2'b10);
      end
      bvalid = 1'b1;
      @(negedge clk);
      bvalid = 1'b0;
      chk("wend_pulse", {wend_o, rend_o}, 2'b10);
      chk("line_kept", line_o, exp_line);
      drop_req(kind);
      @(negedge clk);
      chk("wend_cleared", {wend_o, bready}, 0);
      chk("pulse_counts", {16'(rend_cnt - r0), 16'(wend_cnt - w0)}, {16'd0, 16'd1});
    end
  endtask

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wd;
    logic [31:0] base;
    int          d_a;
    int          d_w;
    int          stall;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{K_CA,  32'h1000_0024, 4'h0, 32'h0, 32'h0000_00A0, 2, 0, 0, 32'h1000_0020, 8'd7};
    vecs[1] = '{K_UCR, 32'h1FAF_0004, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 32'h1FAF_0004, 8'd0};
    vecs[2] = '{K_UCW, 32'h1FAF_0008, 4'b0011, 32'h0000_1234, 32'h0, 3, 0, 0, 32'h1FAF_0008, 8'd0};
    vecs[3] = '{K_UCW, 32'h0000_0100, 4'b1100, 32'hCAFE_F00D, 32'h0, 0, 2, 1, 32'h0000_0100, 8'd0};
    vecs[4] = '{K_UCW, 32'h0000_0203, 4'b1111, 32'h5555_AAAA, 32'h0, 1, 1, 2, 32'h0000_0203, 8'd0};
    vecs[5] = '{K_CA,  32'h0000_003F, 4'h0, 32'h0, 32'hB000_0000, 1, 0, 3, 32'h0000_0020, 8'd7};

    rst_n = 1'b0;
    ca_rreq_i = 0; uc_rreq_i = 0; uc_wreq_i = 0;
    addr_i = '0; wen_i = '0; wdata_i = '0;
    arready = 0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = '0; bvalid = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {arvalid, rready, awvalid, wvalid, bready, rend_o, wend_o}, 0);
    chk("reset_data", {line_o, uc_rdata_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_txn(vecs[i].kind, vecs[i].addr, vecs[i].wen, vecs[i].wd, vecs[i].base,
              vecs[i].d_a, vecs[i].d_w, vecs[i].stall, vecs[i].e_addr, vecs[i].e_len, -1);
    chk("refill_word0", line_o[31:0], 32'hB000_0000);
    chk("refill_word7", line_o[255:224], 32'hB000_0007);
    chk("uc_word", uc_rdata_o, 32'hDEAD_BEEF);

    // all three requests pending at once: served uc read, uc write, then refill
    addr_i = 32'h2000_0044;
    uc_rreq_i = 1'b1; uc_wreq_i = 1'b1; ca_rreq_i = 1'b1;
    run_txn(K_UCR, 32'h2000_0044, 4'b0101, 32'h0BAD_F00D, 32'h7777_0000, 0, 0, 1,
            32'h2000_0044, 8'd0, -1);
    run_txn(K_UCW, 32'h2000_0044, 4'b0101, 32'h0BAD_F00D, 32'h0, 1, 0, 0,
            32'h2000_0044, 8'd0, -1);
    run_txn(K_CA, 32'h2000_0044, 4'b0101, 32'h0BAD_F00D, 32'h8888_0000, 0, 0, 2,
            32'h2000_0040, 8'd7, -1);

    // reset in the middle of a refill, then a clean refill
    run_txn(K_CA, 32'h3000_0000, 4'h0, 32'h0, 32'hC000_0000, 1, 0, 1, 32'h3000_0000, 8'd7, 4);
    run_txn(K_CA, 32'h3000_0040, 4'h0, 32'h0, 32'hD000_0000, 0, 0, 0, 32'h3000_0040, 8'd7, -1);

    for (int n = 0; n < 24; n++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      a = $urandom;
      run_txn(k, a, 4'($urandom), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              m_addr(k, a), m_len(k), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
